// File: rtl/joy_db15_resp_if.sv
// DB15 serial joystick link: shift clock and parallel load from the reader,
// serial data back from the responder.
`timescale 1ns/1ps
interface joy_db15_resp_if;
    logic JOY_CLK;   // idle high, shift on rising edge
    logic JOY_LOAD;  // active-low parallel load
    logic JOY_DATA;  // active-low button data

    modport master (output JOY_CLK, output JOY_LOAD, input JOY_DATA);
    modport slave  (input JOY_CLK, input JOY_LOAD, output JOY_DATA);
endinterface

// File: rtl/joy_db15_resp.sv
// Responder end of the DB15 serial joystick link. Emulates the adapter
// board's 74HC165-style parallel-load shift chain carrying two 16-bit pads.
`timescale 1ns/1ps
module joy_db15_resp #(
    parameter int unsigned FILT    = 2,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned NBITS   = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        joystick1,
    input  logic [15:0]        joystick2,
    joy_db15_resp_if.slave     joy,
    output logic               frame_done,
    output logic [5:0]         bit_cnt,
    output logic               overrun
);

    localparam int unsigned     TW       = $clog2(TIMEOUT + 1);
    localparam logic [5:0]      LastCnt  = 6'(NBITS - 1);
    localparam logic [TW-1:0]   TimerMax = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    // Bit 0 = JOY_CLK, bit 1 = JOY_LOAD.
    logic [1:0] pin;
    logic [1:0] lvl;    // filtered level, valid in the current cycle
    logic [1:0] lvl_q;  // filtered level of the previous cycle

    assign pin = {joy.JOY_LOAD, joy.JOY_CLK};

    for (genvar g = 0; g < 2; g++) begin : g_in
        logic          sync1_q;
        logic          sync2_q;
        logic          flt_q;
        logic [FILT:0] win;  // FILT+1 most recent synchronised samples

        // Two-flop synchroniser for the asynchronous pin.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= pin[g];
                sync2_q <= sync1_q;
            end
        end

        if (FILT == 0) begin : g_nofilt
            assign win = sync2_q;
        end else begin : g_filt
            logic [FILT-1:0] hist_q;

            // Sample history feeding the glitch filter window.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hist_q <= '1;
                end else begin
                    hist_q <= win[FILT-1:0];
                end
            end

            assign win = {hist_q, sync2_q};
        end

        // A level is accepted only once the whole window agrees; otherwise hold.
        assign lvl[g] = (&win) ? 1'b1 : ((~|win) ? 1'b0 : flt_q);

        // Previous accepted level, used for edge detection.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                flt_q <= 1'b1;
            end else begin
                flt_q <= lvl[g];
            end
        end

        assign lvl_q[g] = flt_q;
    end

    logic [1:0]    arm_q;  // reset-release synchroniser gating load acceptance
    state_e        state_q;
    logic [31:0]   sr_q;
    logic [5:0]    bit_cnt_q;
    logic          data_q;
    logic          done_q;
    logic          ovr_q;
    logic [TW-1:0] timer_q;

    logic load_low;
    logic clk_rise;

    assign load_low = arm_q[1] & ~lvl[1];
    assign clk_rise = lvl[0] & ~lvl_q[0];

    // Hold off load acceptance for a couple of cycles after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q <= 2'b00;
        end else begin
            arm_q <= {arm_q[0], 1'b1};
        end
    end

    // Load/shift state machine with registered pin and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            sr_q      <= '1;
            bit_cnt_q <= '0;
            data_q    <= 1'b1;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            timer_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (load_low) begin
                // Load wins over any same-cycle shift edge; transparent while low.
                state_q   <= StLoad;
                sr_q      <= {joystick1, joystick2};
                bit_cnt_q <= '0;
                ovr_q     <= 1'b0;
                data_q    <= ~joystick1[15];
                timer_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        data_q <= 1'b1;
                    end
                    StLoad: begin
                        state_q <= StShift;
                        data_q  <= ~sr_q[31];
                        timer_q <= '0;
                    end
                    StShift: begin
                        if (clk_rise) begin
                            sr_q      <= {sr_q[30:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            timer_q   <= '0;
                            if (bit_cnt_q == LastCnt) begin
                                done_q  <= 1'b1;
                                data_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                data_q <= ~sr_q[30];
                            end
                        end else if (bit_cnt_q != 6'd0) begin
                            // Abandon a stalled frame; before the first shift wait forever.
                            if (timer_q == TimerMax) begin
                                state_q   <= StIdle;
                                bit_cnt_q <= '0;
                                data_q    <= 1'b1;
                                timer_q   <= '0;
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        data_q <= 1'b1;
                        if (clk_rise) begin
                            ovr_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign joy.JOY_DATA = data_q;
    assign frame_done   = done_q;
    assign bit_cnt      = bit_cnt_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_joy_db15_resp.sv
// Bench for joy_db15_resp: directed scenarios plus randomized frames checked
// against a bit-queue model of the wire sequence.
`timescale 1ns/1ps
module tb_joy_db15_resp;

    localparam int unsigned FILT    = 2;
    localparam int unsigned TIMEOUT = 4096;
    localparam int unsigned NBITS   = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        frame_done;
    logic [5:0]  bit_cnt;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    joy_db15_resp_if joy_if ();

    joy_db15_resp #(
        .FILT    (FILT),
        .TIMEOUT (TIMEOUT),
        .NBITS   (NBITS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .joy        (joy_if),
        .frame_done (frame_done),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Advance n cycles, sampling 1 ns after each edge and counting frame_done pulses.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) fd_cnt++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int lo, input int hi);
        joy_if.JOY_CLK = 1'b0;
        tick(lo);
        joy_if.JOY_CLK = 1'b1;
        tick(hi);
    endtask

    // Load a word pair, then apply nclk shift pulses, checking every wire bit.
    task automatic run_frame(input logic [15:0] j1, input logic [15:0] j2,
                             input bit rnd, input int nclk);
        logic [31:0] w;
        bit          q[$];
        int          lo;
        int          hi;
        int          fd0;
        logic        exp;
        w = {j1, j2};
        q = {};
        for (int i = 31; i >= 0; i--) q.push_back(~w[i]);
        joystick1 = j1;
        joystick2 = j2;
        joy_if.JOY_LOAD = 1'b0;
        tick(10);
        joy_if.JOY_LOAD = 1'b1;
        tick(8);
        fd0 = fd_cnt;
        check("first_bit", joy_if.JOY_DATA, q[0]);
        check("load_cnt", bit_cnt, 0);
        for (int k = 1; k <= nclk; k++) begin
            lo = 10;
            hi = 10;
            if (rnd) begin
                lo = int'($urandom_range(3, 12));
                hi = int'($urandom_range(6, 12));
                joystick1 = 16'($urandom);
                joystick2 = 16'($urandom);
            end
            pulse(lo, hi);
            exp = (k < 32) ? q[k] : 1'b1;
            check("shift_data", joy_if.JOY_DATA, exp);
            check("shift_cnt", bit_cnt, k);
        end
        check("frame_done_count", fd_cnt - fd0, (nclk == 32) ? 1 : 0);
    endtask

    initial begin
        logic [15:0] a1;
        logic [15:0] a2;
        int          fd0;

        reset_n         = 1'b0;
        joystick1       = '0;
        joystick2       = '0;
        joy_if.JOY_CLK  = 1'b1;
        joy_if.JOY_LOAD = 1'b1;
        tick(3);
        check("rst_data", joy_if.JOY_DATA, 1);
        check("rst_cnt", bit_cnt, 0);
        check("rst_done", frame_done, 0);
        check("rst_ovr", overrun, 0);
        reset_n = 1'b1;
        tick(5);

        // Directed frame.
        run_frame(16'hA5C3, 16'h0F01, 1'b0, 32);
        check("end_data", joy_if.JOY_DATA, 1);
        check("end_ovr", overrun, 0);

        // Overrun after frame end.
        for (int i = 0; i < 3; i++) pulse(6, 8);
        check("ovr_set", overrun, 1);
        check("ovr_data", joy_if.JOY_DATA, 1);
        check("ovr_cnt", bit_cnt, 32);
        joy_if.JOY_LOAD = 1'b0;
        tick(8);
        check("ovr_clr", overrun, 0);
        check("ovr_clr_cnt", bit_cnt, 0);
        joy_if.JOY_LOAD = 1'b1;
        tick(8);

        // Transparent load, shift edges ignored while LOAD is low.
        joystick1 = 16'h0000;
        joystick2 = 16'h1234;
        joy_if.JOY_LOAD = 1'b0;
        tick(8);
        check("transp_hi", joy_if.JOY_DATA, 1);
        joystick1 = 16'h8000;
        tick(1);
        check("transp_lo", joy_if.JOY_DATA, 0);
        pulse(4, 6);
        pulse(4, 6);
        check("load_clk_ignored", bit_cnt, 0);
        joy_if.JOY_LOAD = 1'b1;
        tick(8);
        check("after_load_cnt", bit_cnt, 0);
        check("after_load_data", joy_if.JOY_DATA, 0);

        // Timeout mid-frame.
        a1 = 16'($urandom);
        a2 = 16'($urandom);
        run_frame(a1, a2, 1'b1, 5);
        fd0 = fd_cnt;
        tick(TIMEOUT + 10);
        check("to_cnt", bit_cnt, 0);
        check("to_data", joy_if.JOY_DATA, 1);
        check("to_no_done", fd_cnt - fd0, 0);
        pulse(4, 8);
        check("to_idle_ignores", bit_cnt, 0);

        // No timeout before the first shift.
        a1 = 16'($urandom);
        a2 = 16'($urandom);
        run_frame(a1, a2, 1'b0, 0);
        tick(TIMEOUT + 10);
        check("wait_cnt", bit_cnt, 0);
        check("wait_data", joy_if.JOY_DATA, {31'd0, ~a1[15]});
        pulse(4, 8);
        check("wait_shift_cnt", bit_cnt, 1);
        check("wait_shift_data", joy_if.JOY_DATA, {31'd0, ~a1[14]});

        // Glitch filter and pin-to-data latency.
        run_frame(16'h5A5A, 16'hC3C3, 1'b0, 0);
        joy_if.JOY_CLK = 1'b0; tick(5);
        joy_if.JOY_CLK = 1'b1; tick(1);
        joy_if.JOY_CLK = 1'b0; tick(5);
        joy_if.JOY_CLK = 1'b1; tick(2);
        joy_if.JOY_CLK = 1'b0; tick(8);
        check("glitch_cnt", bit_cnt, 0);
        check("glitch_data", joy_if.JOY_DATA, 1);
        joy_if.JOY_CLK = 1'b1; tick(3);
        joy_if.JOY_CLK = 1'b0; tick(1);
        check("lat4_data", joy_if.JOY_DATA, 1);
        check("lat4_cnt", bit_cnt, 0);
        tick(1);
        check("lat5_data", joy_if.JOY_DATA, 0);
        check("lat5_cnt", bit_cnt, 1);
        tick(4);
        joy_if.JOY_CLK = 1'b1; tick(8);
        check("post_glitch_cnt", bit_cnt, 2);
        joy_if.JOY_LOAD = 1'b0; tick(2);
        joy_if.JOY_LOAD = 1'b1; tick(8);
        check("load_glitch_cnt", bit_cnt, 2);

        // Reset mid-frame.
        run_frame(16'hA5C3, 16'h0F01, 1'b0, 17);
        reset_n = 1'b0;
        #1;
        check("mid_rst_data", joy_if.JOY_DATA, 1);
        check("mid_rst_cnt", bit_cnt, 0);
        check("mid_rst_done", frame_done, 0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        run_frame(16'hA5C3, 16'h0F01, 1'b0, 32);

        // Randomized frames.
        for (int r = 0; r < 4; r++) begin
            run_frame(16'($urandom), 16'($urandom), 1'b1, 32);
            check("rand_end_data", joy_if.JOY_DATA, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
